// File: rtl/seq_en_pulse_gen.sv
// Purpose : debounces a raw asynchronous request level and emits single-cycle
//           enable pulses on press, with optional auto-repeat while held.
// Latency : en rises in the cycle after edge DEBOUNCE+2 following an in_ rise.
// Backpressure: none. Pulses are fire-and-forget. pressed is the debounced level.
//
// Ports
//   clk        sole clock; all state updates on its rising edge
//   reset      asynchronous active-low reset
//   in_        raw, asynchronous, bouncy request level
//   repeat_en  synchronous; enables auto-repeat pulses while held
//   en         registered single-cycle enable pulse
//   pressed    debounced level: high in HELD and DB_RELEASE
module seq_en_pulse_gen #(
    parameter int DEBOUNCE      = 4,   // 1..15
    parameter int REPEAT_DLY    = 16,  // 2..255
    parameter int REPEAT_PERIOD = 4    // 1..REPEAT_DLY
) (
    input  logic clk,
    input  logic reset,
    input  logic in_,
    input  logic repeat_en,
    output logic en,
    output logic pressed
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    // dcnt holds the number of consecutive qualifying samples seen so far, so
    // the transition fires on the edge where dcnt already equals DEBOUNCE-1.
    localparam logic [3:0] DB_LAST    = 4'(DEBOUNCE - 1);
    // The repeat timer counts HELD cycles with repeat_en high; the pulse is
    // launched on the edge where it has reached REPEAT_DLY-1, so en is seen
    // REPEAT_DLY cycles after HELD entry (or after repeat_en returns).
    localparam logic [7:0] RPT_LAST   = 8'(REPEAT_DLY - 1);
    localparam logic [7:0] RPT_RELOAD = 8'(REPEAT_DLY - REPEAT_PERIOD);

    logic [1:0] sync_q;
    logic       s;
    state_t     state_q, state_d;
    logic [3:0] dcnt_q, dcnt_d;
    logic [7:0] rpt_q, rpt_d;
    logic       en_q, en_d;

    assign s = sync_q[1];

    // Two-flop synchronizer; nothing downstream looks at in_ directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], in_};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dcnt_q  <= 4'd0;
            rpt_q   <= 8'd0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            rpt_q   <= rpt_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        // Timer is cleared in every path except "stay in HELD with repeat_en",
        // which covers clearing on HELD entry and on repeat_en low.
        rpt_d   = 8'd0;
        en_d    = 1'b0;

        case (state_q)
            IDLE: begin
                dcnt_d = 4'd0;
                if (s) begin
                    if (DEBOUNCE == 1) begin
                        state_d = HELD;
                        en_d    = 1'b1;
                    end else begin
                        state_d = DB_PRESS;
                        dcnt_d  = 4'd1;
                    end
                end
            end

            DB_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                    dcnt_d  = 4'd0;
                end else if (dcnt_q == DB_LAST) begin
                    state_d = HELD;
                    dcnt_d  = 4'd0;
                    en_d    = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 4'd1;
                end
            end

            HELD: begin
                dcnt_d = 4'd0;
                if (!s) begin
                    // Leaving HELD never pulses, even if the timer is due.
                    if (DEBOUNCE == 1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DB_RELEASE;
                        dcnt_d  = 4'd1;
                    end
                end else if (repeat_en) begin
                    if (rpt_q == RPT_LAST) begin
                        rpt_d = RPT_RELOAD;
                        en_d  = 1'b1;
                    end else begin
                        rpt_d = rpt_q + 8'd1;
                    end
                end
            end

            DB_RELEASE: begin
                if (s) begin
                    // Glitch low while held: resume without a new pulse.
                    state_d = HELD;
                    dcnt_d  = 4'd0;
                end else if (dcnt_q == DB_LAST) begin
                    state_d = IDLE;
                    dcnt_d  = 4'd0;
                end else begin
                    dcnt_d = dcnt_q + 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
                dcnt_d  = 4'd0;
            end
        endcase
    end

    assign en      = en_q;
    assign pressed = (state_q == HELD) || (state_q == DB_RELEASE);

endmodule

// File: tb/tb_seq_en_pulse_gen.sv
module tb_seq_en_pulse_gen;

    localparam int D   = 4;
    localparam int DLY = 16;
    localparam int PER = 4;

    logic clk = 1'b0;
    logic reset;
    logic in_;
    logic repeat_en;
    logic en;
    logic pressed;
    logic [2:0] cnt3;

    always #5 clk = ~clk;

    seq_en_pulse_gen #(
        .DEBOUNCE      (D),
        .REPEAT_DLY    (DLY),
        .REPEAT_PERIOD (PER)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_       (in_),
        .repeat_en (repeat_en),
        .en        (en),
        .pressed   (pressed)
    );

    // Downstream 3-bit up counter fed by en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt3 <= 3'd0;
        else if (en) cnt3 <= cnt3 + 3'd1;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: debounced level flips once s has disagreed with it for
    // D consecutive edges; repeats counted as a run length of held edges.
    bit m_s1, m_s2, m_pressed, m_en;
    int m_run, m_r, m_cnt;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_pressed = 0; m_en = 0;
        m_run = 0; m_r = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit s, held, nen;
        s    = m_s2;
        held = m_pressed && (m_run == 0);
        nen  = 0;
        if (held && s && repeat_en) begin
            m_r++;
            nen = (m_r >= DLY) && (((m_r - DLY) % PER) == 0);
        end else begin
            m_r = 0;
        end
        if (s != m_pressed) begin
            m_run++;
            if (m_run >= D) begin
                m_pressed = s;
                m_run = 0;
                if (s) nen = 1;
            end
        end else begin
            m_run = 0;
        end
        m_en = nen;
        if (m_en) m_cnt++;
        m_s2 = m_s1;
        m_s1 = in_;
    endtask

    // One clock: drive just after a falling edge, check at the next one.
    task automatic step(input bit in_v, input bit ren, input bit rst_v);
        in_ = in_v;
        repeat_en = ren;
        reset = rst_v;
        if (!rst_v) model_reset();
        @(posedge clk);
        if (rst_v) model_edge();
        @(negedge clk);
        check("model_en", en, m_en);
        check("model_pressed", pressed, m_pressed);
    endtask

    typedef struct {
        bit in_v;
        bit ren;
        bit exp_en;
        bit exp_p;
        int reps;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit a, input bit b, input bit c, input bit d, input int r);
        vec_t v;
        v.in_v = a; v.ren = b; v.exp_en = c; v.exp_p = d; v.reps = r;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].reps; k++) begin
                step(tbl[i].in_v, tbl[i].ren, 1'b1);
                check({name, "_en"}, en, tbl[i].exp_en);
                check({name, "_pressed"}, pressed, tbl[i].exp_p);
            end
        end
        tbl.delete();
    endtask

    task automatic add_release();
        add(0, 0, 0, 1, 5);
        add(0, 0, 0, 0, 3);
    endtask

    initial begin
        bit lvl;
        reset = 1'b0;
        in_ = 1'b0;
        repeat_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_en", en, 1'b0);
        check("reset_pressed", pressed, 1'b0);
        step(0, 0, 1);
        step(0, 0, 1);

        // Clean press, 30 cycles held, no repeat; then release.
        add(1, 0, 0, 0, 5);
        add(1, 0, 1, 1, 1);
        add(1, 0, 0, 1, 24);
        add_release();
        run_table("clean");

        // Bounce: 3 high, 1 low, then high; one pulse 6 edges after final rise.
        add(1, 0, 0, 0, 3);
        add(0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 5);
        add(1, 0, 1, 1, 1);
        add(1, 0, 0, 1, 3);
        add_release();
        run_table("bounce");

        // Auto-repeat: pulses at HELD cycles 0, 16, 20, ..., 36.
        add(1, 1, 0, 0, 5);
        add(1, 1, 1, 1, 1);
        add(1, 1, 0, 1, 15);
        add(1, 1, 1, 1, 1);
        for (int j = 0; j < 5; j++) begin
            add(1, 1, 0, 1, 3);
            add(1, 1, 1, 1, 1);
        end
        add(1, 1, 0, 1, 3);
        add_release();
        run_table("repeat");

        // repeat_en dropping and returning restarts the full delay.
        add(1, 0, 0, 0, 5);
        add(1, 0, 1, 1, 1);
        add(1, 0, 0, 1, 3);
        add(1, 1, 0, 1, 15);
        add(1, 1, 1, 1, 1);
        add(1, 0, 0, 1, 3);
        add(1, 1, 0, 1, 15);
        add(1, 1, 1, 1, 1);
        add(1, 0, 0, 1, 2);
        add_release();
        run_table("rpt_return");

        // Two-cycle low glitch while held: pressed stays, no new pulse.
        add(1, 0, 0, 0, 5);
        add(1, 0, 1, 1, 1);
        add(1, 0, 0, 1, 4);
        add(0, 0, 0, 1, 2);
        add(1, 0, 0, 1, 8);
        add_release();
        run_table("glitch");

        // Reset asserted during the entry pulse, in_ kept high.
        for (int k = 0; k < 5; k++) step(1, 0, 1);
        step(1, 0, 1);
        check("rst_pre_en", en, 1'b1);
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_now_en", en, 1'b0);
        check("rst_now_pressed", pressed, 1'b0);
        for (int k = 0; k < 3; k++) step(1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 1);
            check("rst_after_en", en, 1'b0);
        end
        step(1, 0, 1);
        check("rst_fresh_en", en, 1'b1);
        check("rst_fresh_pressed", pressed, 1'b1);
        for (int k = 0; k < 10; k++) step(0, 0, 1);

        // Ten clean presses wrap the 3-bit counter to 2.
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < 8; k++) step(1, 0, 1);
            for (int k = 0; k < 8; k++) step(0, 0, 1);
        end
        check3("counter_10_presses", cnt3, 3'd2);

        // Random in_/repeat_en/reset against the model.
        lvl = 0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) lvl = ~lvl;
            step(lvl, $urandom_range(0, 9) != 0, $urandom_range(0, 99) != 0);
        end
        for (int k = 0; k < 20; k++) step(0, 0, 1);
        check3("counter_random", cnt3, 3'(m_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_en_pulse_gen.md
SEQ_EN_PULSE_GEN -- requirements
Module: seq_en_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE, default 4: number of consecutive synchronized samples needed to accept a level change (legal range 1..15).
REQ-002 Parameter REPEAT_DLY, default 16: number of held cycles before the first auto-repeat pulse (legal range 2..255).
REQ-003 Parameter REPEAT_PERIOD, default 4: number of cycles between later auto-repeat pulses (legal range 1..REPEAT_DLY).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (block in reset while reset==0).
REQ-006 in_  input  1  raw, asynchronous, bouncy request level (e.g. a button).
REQ-007 repeat_en  input  1  synchronous; enables auto-repeat pulses while held.
REQ-008 en  output  1  single-cycle enable pulse; drives the en input of the downstream 3-bit up counter.
REQ-009 pressed  output  1  debounced level of in_.

Function
REQ-010 in_ SHALL pass through a 2-flop synchronizer; s denotes the second flop's output; the FSM SHALL use only s.
REQ-011 FSM states SHALL be IDLE, DB_PRESS, HELD and DB_RELEASE, with a 4-bit debounce counter dcnt.
REQ-012 IDLE: s==1 SHALL give DB_PRESS with dcnt=1 (or HELD directly if DEBOUNCE==1); otherwise stay in IDLE.
REQ-013 DB_PRESS: s==0 SHALL give IDLE; s==1 SHALL increment dcnt; the edge on which s has been sampled 1 on DEBOUNCE consecutive edges SHALL give HELD.
REQ-014 HELD: s==0 SHALL give DB_RELEASE with dcnt=1 (or IDLE directly if DEBOUNCE==1).
REQ-015 DB_RELEASE: s==1 SHALL give HELD with no en pulse and the repeat timer cleared; DEBOUNCE consecutive s==0 samples SHALL give IDLE.
REQ-016 en SHALL be a flop output, high for exactly one cycle, in the first cycle in HELD after entry from DB_PRESS or IDLE.
REQ-017 Latency: if in_ rises after edge E0 and stays high, en SHALL be 1 in the cycle following edge E(DEBOUNCE+2) and 0 otherwise until the repeat rules apply.
REQ-018 Repeat timer: 8-bit; cleared on HELD entry and whenever repeat_en==0; increments each HELD cycle with repeat_en==1.
REQ-019 Repeat pulse timing: with HELD entry as cycle k=0 and repeat_en continuously 1, en SHALL also be 1 at k=REPEAT_DLY+j*REPEAT_PERIOD (j>=0); the timer SHALL reload to REPEAT_DLY-REPEAT_PERIOD after each repeat pulse.
REQ-020 Repeat after repeat_en returns: if repeat_en drops then returns, the next repeat pulse SHALL come REPEAT_DLY cycles after the return.
REQ-021 pressed SHALL be 1 exactly when state is HELD or DB_RELEASE; en SHALL never be 1 outside HELD.
REQ-022 There SHALL be no pulse on release, and en SHALL never be high for two consecutive cycles unless REPEAT_PERIOD==1.

Reset
REQ-023 While reset==0, all flops (synchronizer, state, dcnt, repeat timer, en) SHALL clear immediately: state=IDLE, en=0, pressed=0.
REQ-024 Reset mid-operation SHALL abandon any press in progress; an in_ still high at reset release SHALL be re-debounced and SHALL give a fresh en pulse after DEBOUNCE+2 edges.

Verification (DEBOUNCE=4, REPEAT_DLY=16, REPEAT_PERIOD=4)
REQ-025 Clean press: in_ 0->1 after E0, held 30 cycles, repeat_en=0 -> en=1 only in the cycle after E6; pressed=1 from E6 onward.
REQ-026 Bounce: in_ high 3 cycles, low 1 cycle, then high -> no pulse from the first burst; exactly one en, 6 edges after the final rise.
REQ-027 Auto-repeat: repeat_en=1, in_ held 40 cycles -> en at HELD cycles 0, 16, 20, 24, 28, 32, 36 only.
REQ-028 Release: in_ falls after edge R0 -> pressed=0 in the cycle after R6, en stays 0; a 2-cycle low glitch while held -> pressed stays 1 and there is no new en.
REQ-029 Reset mid-HELD with in_ high: reset=0 -> en=0 and pressed=0 immediately; after reset=1 -> one en, 6 edges later.
REQ-030 Feeding en into the 3-bit counter: 10 clean presses -> counter reads 2 (wrap-around); random in_/repeat_en/reset for 500 cycles -> matches the cycle-accurate model.
